// File: rtl/deflate_cl_expander.sv
`default_nettype none
// ============================================================================
// Module      : deflate_cl_expander
// Description : Expands DEFLATE code-length symbols (0..18) into a flat array
//               of per-symbol code lengths, one RAM write per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module deflate_cl_expander #(
    parameter int ADDR_W = 9,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_codes,
    input  logic [4:0]        sym,
    input  logic [6:0]        sym_extra,
    input  logic              sym_vld,
    output logic              sym_rdy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [LEN_W-1:0]  wr_data,
    output logic              finish,
    output logic              busy,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_REPEAT = 3'd2,
        S_DONE   = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    // Overflow sum needs ADDR_W+1 bits, and at least enough to hold a full 138 run.
    localparam int SUM_W = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] total;
    logic [LEN_W-1:0]  prev;
    logic [7:0]        rep_left;
    logic [LEN_W-1:0]  rep_val;

    logic              is_run;
    logic [7:0]        run_len;
    logic [LEN_W-1:0]  run_val;
    logic [LEN_W-1:0]  lit_val;
    logic [SUM_W-1:0]  run_end;
    logic              illegal;
    logic [ADDR_W-1:0] cnt_inc;
    logic              last_wr;

    always_comb begin
        is_run  = (sym >= 5'd16) && (sym <= 5'd18);
        run_len = 8'd0;
        run_val = '0;
        case (sym)
            5'd16: begin
                run_len = 8'd3 + {6'd0, sym_extra[1:0]};
                run_val = prev;
            end
            5'd17:   run_len = 8'd3 + {5'd0, sym_extra[2:0]};
            5'd18:   run_len = 8'd11 + {1'b0, sym_extra[6:0]};
            default: run_len = 8'd0;
        endcase
        lit_val = LEN_W'(sym[3:0]);
        run_end = SUM_W'(cnt) + SUM_W'(run_len);
        illegal = (sym > 5'd18)
                | ((sym == 5'd16) && (cnt == '0))
                | (is_run && (run_end > SUM_W'(total)));
        cnt_inc = cnt + ADDR_W'(1);
        last_wr = (cnt_inc == total);
    end

    assign sym_rdy = (state == S_ACCEPT);
    assign busy    = (state == S_ACCEPT) || (state == S_REPEAT);
    assign error   = (state == S_ERROR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            total    <= '0;
            prev     <= '0;
            rep_left <= '0;
            rep_val  <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            finish   <= 1'b0;
        end else begin
            wr_en  <= 1'b0;
            finish <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        total    <= num_codes;
                        cnt      <= '0;
                        prev     <= '0;
                        rep_left <= '0;
                        state    <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (sym_vld) begin
                        if (illegal) begin
                            state <= S_ERROR;
                        end else begin
                            // Runs issue their first element in the accept cycle.
                            wr_en   <= 1'b1;
                            wr_addr <= cnt;
                            cnt     <= cnt_inc;
                            if (is_run) begin
                                wr_data  <= run_val;
                                prev     <= run_val;
                                rep_val  <= run_val;
                                rep_left <= run_len - 8'd1;
                            end else begin
                                wr_data <= lit_val;
                                prev    <= lit_val;
                            end
                            if (last_wr) begin
                                finish <= 1'b1;
                                state  <= S_DONE;
                            end else if (is_run) begin
                                state <= S_REPEAT;
                            end
                        end
                    end
                end
                S_REPEAT: begin
                    wr_en    <= 1'b1;
                    wr_addr  <= cnt;
                    wr_data  <= rep_val;
                    cnt      <= cnt_inc;
                    rep_left <= rep_left - 8'd1;
                    if (last_wr) begin
                        finish <= 1'b1;
                        state  <= S_DONE;
                    end else if (rep_left == 8'd1) begin
                        state <= S_ACCEPT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_deflate_cl_expander.sv
`default_nettype none
// ============================================================================
// Module      : tb_deflate_cl_expander
// Description : Table-driven bench for the code-length expander.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_deflate_cl_expander;

    localparam int ADDR_W = 9;
    localparam int LEN_W  = 4;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              start     = 1'b0;
    logic [ADDR_W-1:0] num_codes = '0;
    logic [4:0]        sym       = '0;
    logic [6:0]        sym_extra = '0;
    logic              sym_vld   = 1'b0;
    logic              sym_rdy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [LEN_W-1:0]  wr_data;
    logic              finish;
    logic              busy;
    logic              error;

    deflate_cl_expander #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_codes(num_codes),
        .sym(sym), .sym_extra(sym_extra), .sym_vld(sym_vld), .sym_rdy(sym_rdy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .finish(finish), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] sym;
        logic [6:0] extra;
        int         nwr;
        logic [3:0] val;
    } vec_t;

    vec_t tbl[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int epoch = 0;
    int base_wr, base_fin, base_hs;

    logic [3:0] img    [0:511];
    int         img_ep [0:511] = '{default: -1};
    int         wr_cyc [0:2047];
    int         hs_cyc [0:2047];
    int         wr_cnt = 0;
    int         fin_cnt = 0;
    int         fin_addr = -1;
    int         hs_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Image capture; outputs are sampled on the falling edge.
    always @(negedge clk) begin
        if (wr_en) begin
            img[wr_addr]    = wr_data;
            img_ep[wr_addr] = epoch;
            if (wr_cnt < 2048) wr_cyc[wr_cnt] = cyc;
            wr_cnt++;
        end
        if (finish) begin
            fin_cnt++;
            fin_addr = int'(wr_addr);
        end
        if (rst_n && sym_vld && sym_rdy) begin
            if (hs_cnt < 2048) hs_cyc[hs_cnt] = cyc;
            hs_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] img_at(input int a);
        if (img_ep[a] == epoch) return {28'd0, img[a]};
        return 'x;
    endfunction

    function automatic void add(input int s, input int e, input int n, input int v);
        vec_t x;
        x.sym = 5'(s); x.extra = 7'(e); x.nwr = n; x.val = 4'(v);
        tbl.push_back(x);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic begin_table(input int n);
        tick(1);
        epoch++;
        base_wr = wr_cnt; base_fin = fin_cnt; base_hs = hs_cnt;
        num_codes = ADDR_W'(n);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send(input logic [4:0] s, input logic [6:0] e);
        int t;
        t = 0;
        sym = s; sym_extra = e; sym_vld = 1'b1;
        while (sym_rdy !== 1'b1 && t < 400) begin tick(1); t++; end
        if (t >= 400) begin
            n_chk++; n_fail++;
            $display("FAIL send timeout: sym_rdy=%b, expected 1", sym_rdy);
        end else begin
            tick(1);
        end
    endtask

    task automatic wait_fin();
        int t;
        t = 0;
        while (fin_cnt == base_fin && t < 600) begin tick(1); t++; end
        tick(2);
    endtask

    task automatic run_case(input string name, input int lo, input int hi, input int n, input bit gaps);
        int a;
        logic [31:0] got;
        begin_table(n);
        chk({name, " rdy after start"}, sym_rdy, 1);
        chk({name, " error after start"}, error, 0);
        for (int i = lo; i <= hi; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                sym_vld = 1'b0;
                tick($urandom_range(1, 3));
            end
            send(tbl[i].sym, tbl[i].extra);
        end
        sym_vld = 1'b0;
        wait_fin();
        a = 0;
        for (int i = lo; i <= hi; i++) begin
            got = {28'd0, tbl[i].val};
            for (int k = 0; k < tbl[i].nwr; k++)
                if (img_at(a + k) !== {28'd0, tbl[i].val}) got = img_at(a + k);
            chk($sformatf("%s vec%0d @%0d", name, i - lo, a), got, {28'd0, tbl[i].val});
            a += tbl[i].nwr;
        end
        chk({name, " write count"}, wr_cnt - base_wr, n);
        chk({name, " finish count"}, fin_cnt - base_fin, 1);
        chk({name, " finish addr"}, fin_addr, n - 1);
        chk({name, " busy after"}, busy, 0);
        chk({name, " error after"}, error, 0);
    endtask

    int t1_lo, t1_hi, t2_lo, t2_hi, t3_lo, t3_hi, sm_lo, sm_hi, t6_lo, t6_hi;
    int wr_snap;
    logic [31:0] got;

    initial begin
        // Expected values: {sym, extra, writes, value}
        t1_lo = tbl.size();
        for (int i = 0; i < 16; i++) add(i, 0, 1, i);
        add(0, 0, 1, 0); add(1, 0, 1, 1); add(2, 0, 1, 2);
        t1_hi = tbl.size() - 1;
        t2_lo = tbl.size();
        add(8, 0, 1, 8); add(16, 3, 6, 8); add(17, 0, 3, 0);
        t2_hi = tbl.size() - 1;
        t3_lo = tbl.size();
        add(18, 127, 138, 0); add(18, 127, 138, 0);
        for (int i = 0; i < 44; i++) add(5, 0, 1, 5);
        t3_hi = tbl.size() - 1;
        sm_lo = tbl.size();
        add(2, 0, 1, 2); add(16, 0, 3, 2);
        sm_hi = tbl.size() - 1;
        t6_lo = tbl.size();
        add(17, 7, 10, 0); add(5, 0, 1, 5); add(16, 2, 5, 5); add(18, 100, 111, 0);
        add(7, 0, 1, 7); add(7, 0, 1, 7); add(8, 0, 1, 8); add(9, 0, 1, 9);
        add(16, 0, 3, 9); add(18, 127, 138, 0); add(3, 0, 1, 3); add(16, 3, 6, 3);
        add(17, 4, 7, 0); add(4, 0, 1, 4);
        t6_hi = tbl.size() - 1;

        #12;
        chk("reset outputs", {sym_rdy, wr_en, wr_addr, wr_data, finish, busy, error}, 0);
        #1 rst_n = 1'b1;
        tick(2);

        run_case("literals", t1_lo, t1_hi, 19, 1'b0);
        chk("literals write spacing", wr_cyc[base_wr + 18] - wr_cyc[base_wr], 18);

        run_case("repeat prev", t2_lo, t2_hi, 10, 1'b0);
        chk("repeat prev stall", hs_cyc[base_hs + 2] - hs_cyc[base_hs + 1], 6);

        run_case("long zeros", t3_lo, t3_hi, 320, 1'b0);
        chk("long zeros run1 gap", hs_cyc[base_hs + 1] - hs_cyc[base_hs], 138);
        chk("long zeros run2 gap", hs_cyc[base_hs + 2] - hs_cyc[base_hs + 1], 138);
        chk("long zeros write span", wr_cyc[base_wr + 319] - wr_cyc[base_wr], 319);

        // 16 with nothing written yet
        begin_table(10);
        send(5'd16, 7'd0);
        sym_vld = 1'b0;
        chk("err16 error", error, 1);
        chk("err16 rdy", sym_rdy, 0);
        tick(5);
        chk("err16 no writes", wr_cnt - base_wr, 0);
        chk("err16 busy", busy, 0);

        // run of 5 with only 4 slots left
        begin_table(5);
        send(5'd3, 7'd0);
        send(5'd17, 7'd2);
        sym_vld = 1'b0;
        chk("overflow error", error, 1);
        tick(4);
        chk("overflow writes", wr_cnt - base_wr, 1);
        chk("overflow addr0", img_at(0), 3);
        chk("overflow finish", fin_cnt - base_fin, 0);

        begin_table(10);
        send(5'd19, 7'd0);
        sym_vld = 1'b0;
        chk("sym19 error", error, 1);
        tick(2);
        chk("sym19 no writes", wr_cnt - base_wr, 0);

        run_case("restart from error", sm_lo, sm_hi, 4, 1'b0);

        // start pulsed during a run must be ignored
        begin_table(20);
        send(5'd18, 7'd0);
        sym_vld = 1'b0;
        tick(2);
        num_codes = 9'd5;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        send(5'd17, 7'd6);
        sym_vld = 1'b0;
        wait_fin();
        got = 0;
        for (int a = 0; a < 20; a++) if (img_at(a) !== 0) got = img_at(a);
        chk("midstart image", got, 0);
        chk("midstart writes", wr_cnt - base_wr, 20);
        chk("midstart finish addr", fin_addr, 19);
        chk("midstart error", error, 0);

        // asynchronous reset in the middle of a run
        begin_table(50);
        send(5'd18, 7'd20);
        sym_vld = 1'b0;
        tick(5);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset outputs", {sym_rdy, wr_en, wr_addr, wr_data, finish, busy, error}, 0);
        wr_snap = wr_cnt;
        tick(2);
        #2 rst_n = 1'b1;
        tick(40);
        chk("midreset no finish", fin_cnt - base_fin, 0);
        chk("midreset no writes", wr_cnt - wr_snap, 0);
        chk("midreset idle busy", busy, 0);

        run_case("after reset", sm_lo, sm_hi, 4, 1'b0);
        run_case("gapped mix", t6_lo, t6_hi, 287, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/deflate_cl_expander.md
# deflate_cl_expander

Parametrised successor to the zero-run code-length extractor. Takes decoded code-length-alphabet symbols (0..18, with their extra-bit values already extracted) and expands them into a flat array of per-symbol code lengths. Covers the full literal/length plus distance set: literals 0..15, repeat-previous (16), and short/long zero runs (17/18). Sits between the code-length Huffman decoder and the tree-build RAM, and writes one code length per cycle into that RAM.

## Interface
- `ADDR_W`, default 9: width of the write address and of the `num_codes` count.
- `LEN_W`, default 4: width of a code length (values 0..15).
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse; loads `num_codes` and begins a new table. Ignored unless in IDLE, DONE or ERROR.
- `num_codes` in ADDR_W: total lengths to produce, HLIT+257+HDIST+1. Legal range 1..2^ADDR_W−1.
- `sym` in 5: code-length symbol, 0..18.
- `sym_extra` in 7: extra-bit value for the symbol, LSB-aligned. Only bits 1:0 are used for 16, bits 2:0 for 17, bits 6:0 for 18.
- `sym_vld` in 1: `sym`/`sym_extra` valid.
- `sym_rdy` out 1: block accepts a symbol this cycle.
- `wr_en` out 1: registered write strobe.
- `wr_addr` out ADDR_W: registered write address.
- `wr_data` out LEN_W: registered code length.
- `finish` out 1: one-cycle pulse coincident with the final `wr_en`.
- `busy` out 1: high in ACCEPT or REPEAT.
- `error` out 1: sticky, high in ERROR.

## Operation
- **Handshake:** a symbol is accepted when `sym_vld & sym_rdy`. `sym_rdy = (state==ACCEPT)`, derived combinationally from state only.
- **Internal state:**
  - `cnt` (ADDR_W): next address.
  - `total` (ADDR_W): latched `num_codes`.
  - `prev` (LEN_W): last written length, reset 0.
  - `rep_left` (8 bits): writes remaining in the current run.
  - `rep_val` (LEN_W): value being repeated.
- **States:**
  - **IDLE:** on `start`, latch `total`, clear `cnt` and `prev`, go to ACCEPT.
  - **ACCEPT, symbol 0..15:** write `sym` at `cnt`, set `prev = sym`, increment `cnt`.
  - **ACCEPT, symbol 16:** run = 3 + `extra[1:0]` (3..6), value = `prev`.
  - **ACCEPT, symbol 17:** run = 3 + `extra[2:0]` (3..10), value = 0.
  - **ACCEPT, symbol 18:** run = 11 + `extra[6:0]` (11..138), value = 0.
  - **ACCEPT, run accepted:** write the first element the same cycle, set `rep_left = run−1`, go to REPEAT.
  - **REPEAT:** one write per cycle of `rep_val` at `cnt`, decrementing `rep_left`. When `rep_left` reaches 0, return to ACCEPT, or go to DONE if `cnt` has reached `total`.
  - **Completion:** when the write at address `total−1` is issued, go to DONE. This applies from both ACCEPT and REPEAT.
  - **DONE:** idle until `start`.
  - **ERROR:** entered on an illegal symbol; the symbol is consumed and nothing is written for it. Left only on `start` or reset.
- **Error conditions:**
  - `sym` > 18.
  - Symbol 16 with `cnt==0` (no previous length).
  - A run overflowing the table: `cnt + run > total`. Evaluated with ADDR_W+1-bit arithmetic.
- **Run update:** a run updates `prev` to `rep_val` (for 17/18 `prev` becomes 0).
- **Wrap / limits:** `cnt` never exceeds `total`; address wrap is impossible by construction.
- **`start` while busy:** ignored. A `start` in DONE or ERROR clears `error` and restarts.

## Timing
- **Reset values:** `sym_rdy` = 0, `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0, `finish` = 0, `busy` = 0, `error` = 0, state IDLE.
- **Start latency:** `start` in cycle t gives `sym_rdy` = 1 in t+1.
- **Literal symbol:** accepted in cycle t; `wr_en`/`wr_addr`/`wr_data` valid in t+1. Back-to-back literals sustain one write per cycle.
- **Repeat symbol:** accepted in cycle t; writes land in cycles t+1 .. t+run with consecutive addresses. `sym_rdy` is low from t+1 to t+run−1 and high again at t+run if not DONE. A following symbol can therefore be accepted in the same cycle the last run write appears.
- **`finish`:** asserted with the `wr_en` for address `total−1`. `busy` is low from the next cycle.
- **`error`:** asserts the cycle after the offending handshake. No `wr_en` is issued from then on.
- **Reset mid-run:** all state cleared immediately. A partial table is left in RAM, with no `finish`.

## Test plan
1. **Literals only:** `start` with `num_codes=19`; symbols 0..15 then 0,1,2, `sym_vld` held high. Expect writes at addr 0..18 with those values on consecutive cycles, and `finish` with the addr 18 write.
2. **Repeat previous:** `num_codes=10`; symbols 8, then 16 with extra=3. Expect addr 0 = 8 and addr 1..6 = 8. `sym_rdy` is low for 5 cycles, then symbol 17 with extra=0 writes addr 7..9 = 0 and `finish` pulses.
3. **Max long zero run:** `num_codes=320`; 18 extra=127 (138 zeros), 18 extra=127, then 44 literal 5s. Expect 138+138 zeros at 0..275, then 5s at 276..319. `finish` at addr 319; no stall beyond the run lengths.
4. **Errors:**
   - 16 as the first symbol gives `error=1` and no `wr_en`.
   - Separately, `num_codes=5`, then 3, then 17 extra=2 (run 5 > 4 remaining) gives `error` with only addr 0 written.
   - `sym=19` gives `error`.
5. **Restart / reset:**
   - `start` pulsed mid-run is ignored, and the run completes.
   - `rst_n` low mid-run clears all outputs asynchronously, and `finish` never fires.
   - A fresh `start` afterwards produces a correct table from addr 0.
6. **Backpressure gaps:** `sym_vld` toggled randomly during a mixed 257+30 stream. The written image matches the reference model, with one write per accepted literal and `run` writes per repeat symbol.
